fwd_pipe: RTL and testbench
===========================

FWD_PIPE -- requirements
Module: fwd_pipe

Interface
REQ-001 SHALL have parameter DW, default 8, datapath width matching the 8-bit operand muxes.
REQ-002 SHALL have parameter AW, default 3, register-address width (8 registers, r0 hardwired zero).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ex_we  input  1  EX-stage instruction writes a register.
REQ-006 SHALL have port ex_load  input  1  EX-stage instruction is a load.
REQ-007 SHALL have port ex_rd  input  AW  EX-stage destination register.
REQ-008 SHALL have port ex_result  input  DW  EX-stage ALU result (also load address).
REQ-009 SHALL have port mem_rdata  input  DW  data-memory read data for the MEM-stage load, valid same cycle.
REQ-010 SHALL have ports id_rs, id_rt  input  AW each  ID-stage source registers.
REQ-011 SHALL have ports stall, flush  input  1 each  pipeline hold; bubble insertion into MEM.
REQ-012 SHALL have ports fwd_a_sel, fwd_b_sel  output  2 each  select codes for the rs/rt 3-input operand muxes.
REQ-013 SHALL have ports mem_fwd, wb_fwd  output  DW each  data for mux inputs d1, d2.
REQ-014 SHALL have ports wb_we, wb_rd, wb_data  output  1/AW/DW  register-file write port.
REQ-015 SHALL have port load_use  output  1  load-use hazard request to the stall logic.

Function
REQ-016 SHALL hold two stage registers, MEM {we, load, rd, result} and WB {we, rd, data}.
REQ-017 SHALL, on a clk edge with stall=0 and flush=0, load MEM from ex_* and WB from MEM.
REQ-018 SHALL, when moving MEM to WB, set WB.data = mem_rdata if MEM.load else MEM.result.
REQ-019 SHALL, with flush=1, clear MEM.we and MEM.load (bubble) while WB still advances from MEM.
REQ-020 SHALL, with stall=1 and flush=0, hold MEM and WB unchanged.
REQ-021 SHALL give flush priority over stall when both are 1.
REQ-022 SHALL force MEM.we=0 whenever ex_rd=0 so r0 never forwards or writes.
REQ-023 SHALL drive mem_fwd = MEM.result and wb_fwd = WB.data combinationally.
REQ-024 SHALL compute each select combinationally (zero latency): 01 if MEM.we and MEM.rd equals the source and the source is nonzero; else 10 if WB.we and WB.rd equals the source and the source is nonzero; else 00; code 11 SHALL never be produced.
REQ-025 SHALL assert load_use combinationally when MEM.load, MEM.we and MEM.rd is nonzero and equals id_rs or id_rt.
REQ-026 SHALL drive wb_we = WB.we, wb_rd = WB.rd, wb_data = WB.data.
REQ-027 SHALL give a result latency of 1 cycle to mem_fwd and 2 cycles to wb_fwd/wb_data.

Reset
REQ-028 SHALL, on clk edge with reset=1, clear every MEM and WB field to 0, overriding stall and flush.
REQ-029 SHALL therefore output sel=00, load_use=0, wb_we=0 and zero data in the cycle after reset.
REQ-030 SHALL discard in-flight instructions on reset mid-operation; no register-file write follows.

Structure
REQ-031 SHALL take DW, AW and the select codes (SEL_RF=00, SEL_MEM=01, SEL_WB=10) from the shared processor package.
REQ-032 SHALL instantiate one sub-module fwd_cmp, used twice (rs, rt), mapping a source address plus MEM/WB state to a select code.

Verification
REQ-033 SHALL verify that ex_we=1, ex_rd=3, ex_result=8'h5A, then id_rs=3 gives fwd_a_sel=01 and mem_fwd=5A; on the next edge, with no new write to r3, it gives fwd_a_sel=10 and wb_fwd=5A.
REQ-034 SHALL verify that with MEM and WB both holding rd=2 (MEM=8'h11, WB=8'h22), id_rt=2 gives fwd_b_sel=01 (MEM priority).
REQ-035 SHALL verify that ex_load=1, ex_rd=4 then id_rs=4 gives load_use=1; with mem_rdata=8'hC3, the next edge gives wb_data=C3 and wb_we=1.
REQ-036 SHALL verify that ex_rd=0, ex_we=1 then id_rs=0 gives fwd_a_sel=00, and that two edges later wb_we=0.
REQ-037 SHALL verify that stall=1 for 3 cycles leaves all outputs constant, and that stall=1 with flush=1 clears MEM.we while WB advances.
REQ-038 SHALL verify that reset=1 asserted with MEM and WB valid gives wb_we=0, sel=00 and load_use=0 after the next edge.

Source files
------------

// File: rtl/fwd_pipe_pkg.sv
// Shared processor definitions for the EX/MEM/WB forwarding block:
// default widths and the operand-mux select codes.
package fwd_pipe_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/fwd_pipe_if.sv
// Bundle of pipeline inputs (EX/ID/control) and forwarding/write-back outputs.
// master = pipeline control side, slave = the forwarding unit.
interface fwd_pipe_if #(
    parameter int DW = fwd_pipe_pkg::DW,
    parameter int AW = fwd_pipe_pkg::AW
);
    import fwd_pipe_pkg::*;

    logic          ex_we;
    logic          ex_load;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          stall;
    logic          flush;

    fwd_sel_t      fwd_a_sel;
    fwd_sel_t      fwd_b_sel;
    logic [DW-1:0] mem_fwd;
    logic [DW-1:0] wb_fwd;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          load_use;

    modport master (
        output ex_we, ex_load, ex_rd, ex_result, mem_rdata, id_rs, id_rt, stall, flush,
        input  fwd_a_sel, fwd_b_sel, mem_fwd, wb_fwd, wb_we, wb_rd, wb_data, load_use
    );

    modport slave (
        input  ex_we, ex_load, ex_rd, ex_result, mem_rdata, id_rs, id_rt, stall, flush,
        output fwd_a_sel, fwd_b_sel, mem_fwd, wb_fwd, wb_we, wb_rd, wb_data, load_use
    );

endinterface

// File: rtl/fwd_pipe_cmp.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer
// of a source register, never forwarding for r0.
module fwd_cmp #(
    parameter int AW = fwd_pipe_pkg::AW
) (
    input  logic                   [AW-1:0] src,
    input  logic                            mem_we,
    input  logic                   [AW-1:0] mem_rd,
    input  logic                            wb_we,
    input  logic                   [AW-1:0] wb_rd,
    output fwd_pipe_pkg::fwd_sel_t          sel
);
    import fwd_pipe_pkg::*;

    // NOTE: the default is assigned first so every path drives sel and no latch is inferred.
    always_comb begin
        sel = SEL_RF;
        if (src != '0) begin
            if (mem_we && (mem_rd == src)) begin
                sel = SEL_MEM;
            end else if (wb_we && (wb_rd == src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_pipe.sv
// EX->MEM->WB stage registers with operand-forwarding selects, load-use
// detection and the register-file write port.
module fwd_pipe #(
    parameter int DW = fwd_pipe_pkg::DW,
    parameter int AW = fwd_pipe_pkg::AW
) (
    input  logic       clk,
    input  logic       reset,
    fwd_pipe_if.slave  bus
);
    import fwd_pipe_pkg::*;

    typedef struct packed {
        logic          we;
        logic          load;
        logic [AW-1:0] rd;
        logic [DW-1:0] result;
    } mem_stage_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_stage_t;

    mem_stage_t mem_q;
    wb_stage_t  wb_q;
    logic       advance;

    // A flush always moves the pipe (bubble into MEM), even while stalled.
    assign advance = bus.flush || !bus.stall;

    // NOTE: stage state uses non-blocking assignments so MEM->WB reads the pre-edge MEM value.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (advance) begin
            wb_q.we   <= mem_q.we;
            wb_q.rd   <= mem_q.rd;
            wb_q.data <= mem_q.load ? bus.mem_rdata : mem_q.result;

            // Writes to r0 are dropped at entry so r0 never forwards or writes back.
            mem_q.we     <= bus.ex_we && (bus.ex_rd != '0) && !bus.flush;
            mem_q.load   <= bus.ex_load && !bus.flush;
            mem_q.rd     <= bus.ex_rd;
            mem_q.result <= bus.ex_result;
        end
    end

    fwd_cmp #(.AW(AW)) u_cmp_rs (
        .src    (bus.id_rs),
        .mem_we (mem_q.we),
        .mem_rd (mem_q.rd),
        .wb_we  (wb_q.we),
        .wb_rd  (wb_q.rd),
        .sel    (bus.fwd_a_sel)
    );

    fwd_cmp #(.AW(AW)) u_cmp_rt (
        .src    (bus.id_rt),
        .mem_we (mem_q.we),
        .mem_rd (mem_q.rd),
        .wb_we  (wb_q.we),
        .wb_rd  (wb_q.rd),
        .sel    (bus.fwd_b_sel)
    );

    assign bus.mem_fwd  = mem_q.result;
    assign bus.wb_fwd   = wb_q.data;
    assign bus.wb_we    = wb_q.we;
    assign bus.wb_rd    = wb_q.rd;
    assign bus.wb_data  = wb_q.data;

    // Load data is not available until WB, so a dependent ID instruction must wait.
    assign bus.load_use = mem_q.load && mem_q.we && (mem_q.rd != '0) &&
                          ((mem_q.rd == bus.id_rs) || (mem_q.rd == bus.id_rt));

endmodule

// File: tb/tb_fwd_pipe.sv
// Self-checking bench for fwd_pipe: directed hazard scenarios plus a
// scoreboard of expected register-file writes.
module tb_fwd_pipe;
    import fwd_pipe_pkg::*;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ex_rdata;
    sb_entry_t   sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    fwd_pipe_if #(.DW(8), .AW(3)) bus ();

    fwd_pipe #(.DW(8), .AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_ex(input logic we, input logic load, input logic [2:0] rd,
                          input logic [7:0] result, input logic [7:0] rdata);
        bus.ex_we     = we;
        bus.ex_load   = load;
        bus.ex_rd     = rd;
        bus.ex_result = result;
        ex_rdata      = rdata;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    endtask

    // One clock: record the write the EX instruction should eventually make,
    // supply load data once a load sits in MEM, and retire any WB write.
    task automatic cycle();
        logic      adv;
        logic      load_in;
        sb_entry_t ent;
        adv     = !reset && (bus.flush || !bus.stall);
        load_in = !reset && !bus.flush && !bus.stall && bus.ex_load;
        if (!reset && !bus.flush && !bus.stall && bus.ex_we && bus.ex_rd != 3'd0) begin
            ent.rd   = bus.ex_rd;
            ent.data = bus.ex_load ? ex_rdata : bus.ex_result;
            sb.push_back(ent);
        end
        @(posedge clk);
        #1;
        if (load_in) bus.mem_rdata = ex_rdata;
        if (adv && bus.wb_we) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                check("sb_rd", 32'(bus.wb_rd), 32'(ent.rd));
                check("sb_data", 32'(bus.wb_data), 32'(ent.data));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.mem_rdata = 8'h00;
        bus.id_rs     = 3'd0;
        bus.id_rt     = 3'd0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        check("rst_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        check("rst_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        check("rst_load_use", 32'(bus.load_use), 32'd0);
        check("rst_wb_we", 32'(bus.wb_we), 32'd0);
        check("rst_wb_data", 32'(bus.wb_data), 32'd0);
        check("rst_mem_fwd", 32'(bus.mem_fwd), 32'd0);

        // MEM forward, then WB forward of the same result
        set_ex(1'b1, 1'b0, 3'd3, 8'h5A, 8'h00);
        bus.id_rs = 3'd3;
        cycle();
        check("fwd_mem_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_MEM));
        check("fwd_mem_data", 32'(bus.mem_fwd), 32'h5A);
        check("fwd_r0_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        idle();
        cycle();
        check("fwd_wb_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_WB));
        check("fwd_wb_data", 32'(bus.wb_fwd), 32'h5A);

        // MEM takes priority over WB for the same register
        set_ex(1'b1, 1'b0, 3'd2, 8'h22, 8'h00);
        cycle();
        set_ex(1'b1, 1'b0, 3'd2, 8'h11, 8'h00);
        bus.id_rs = 3'd0;
        bus.id_rt = 3'd2;
        cycle();
        check("prio_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_MEM));
        check("prio_mem_fwd", 32'(bus.mem_fwd), 32'h11);
        check("prio_wb_fwd", 32'(bus.wb_fwd), 32'h22);
        idle();
        cycle();
        check("prio_b_sel_wb", 32'(bus.fwd_b_sel), 32'(SEL_WB));
        cycle();
        check("prio_b_sel_rf", 32'(bus.fwd_b_sel), 32'(SEL_RF));

        // Load-use hazard and load data into write-back
        set_ex(1'b1, 1'b1, 3'd4, 8'h10, 8'hC3);
        bus.id_rs = 3'd4;
        bus.id_rt = 3'd0;
        cycle();
        check("lu_load_use", 32'(bus.load_use), 32'd1);
        check("lu_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_MEM));
        idle();
        cycle();
        check("lu_wb_data", 32'(bus.wb_data), 32'hC3);
        check("lu_wb_we", 32'(bus.wb_we), 32'd1);
        check("lu_wb_rd", 32'(bus.wb_rd), 32'd4);
        check("lu_cleared", 32'(bus.load_use), 32'd0);
        cycle();

        // r0 destination never forwards or writes
        set_ex(1'b1, 1'b1, 3'd0, 8'h77, 8'h99);
        bus.id_rs = 3'd0;
        cycle();
        check("r0_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        check("r0_load_use", 32'(bus.load_use), 32'd0);
        idle();
        cycle();
        check("r0_wb_we", 32'(bus.wb_we), 32'd0);

        // Stall holds both stages; stall+flush bubbles MEM while WB advances
        set_ex(1'b1, 1'b0, 3'd5, 8'hA1, 8'h00);
        cycle();
        set_ex(1'b1, 1'b0, 3'd6, 8'hB2, 8'h00);
        cycle();
        bus.id_rs = 3'd6;
        bus.id_rt = 3'd5;
        set_ex(1'b1, 1'b0, 3'd7, 8'hEE, 8'h00);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_MEM));
            check("stall_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_WB));
            check("stall_mem_fwd", 32'(bus.mem_fwd), 32'hB2);
            check("stall_wb_data", 32'(bus.wb_data), 32'hA1);
            check("stall_wb_rd", 32'(bus.wb_rd), 32'd5);
            check("stall_wb_we", 32'(bus.wb_we), 32'd1);
        end
        bus.flush = 1'b1;
        cycle();
        check("flush_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_WB));
        check("flush_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        check("flush_wb_rd", 32'(bus.wb_rd), 32'd6);
        check("flush_wb_data", 32'(bus.wb_data), 32'hB2);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        cycle();
        check("flush_bubble_we", 32'(bus.wb_we), 32'd0);

        // Reset mid-operation discards in-flight instructions
        set_ex(1'b1, 1'b0, 3'd3, 8'h33, 8'h00);
        cycle();
        set_ex(1'b1, 1'b1, 3'd4, 8'h20, 8'h44);
        bus.id_rs = 3'd4;
        bus.id_rt = 3'd3;
        cycle();
        check("pre_rst_load_use", 32'(bus.load_use), 32'd1);
        reset     = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        cycle();
        sb.delete();
        check("mid_rst_wb_we", 32'(bus.wb_we), 32'd0);
        check("mid_rst_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        check("mid_rst_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        check("mid_rst_load_use", 32'(bus.load_use), 32'd0);
        check("mid_rst_mem_fwd", 32'(bus.mem_fwd), 32'd0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        cycle();
        check("post_rst_wb_we", 32'(bus.wb_we), 32'd0);
        cycle();
        check("post_rst_wb_we2", 32'(bus.wb_we), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
